// File: rtl/yscaler_wrapper.sv
// Streaming nearest-neighbour vertical scaler for 8-bit grayscale AXI4-Stream video.
// Input lines land in a ping-pong pair of line buffers and are replayed or dropped per output line.
module yscaler_wrapper #(
  parameter int C_PIXEL_WIDTH = 8,
  parameter int C_RES_WIDTH   = 12,
  parameter int C_MAX_WIDTH   = 4096
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [C_RES_WIDTH-1:0]   ori_height,
  input  logic [C_RES_WIDTH-1:0]   ori_width,
  input  logic [C_RES_WIDTH-1:0]   scale_height,
  input  logic [C_RES_WIDTH-1:0]   scale_width,
  input  logic [C_PIXEL_WIDTH-1:0] S_AXIS_tdata,
  input  logic                     S_AXIS_tvalid,
  output logic                     S_AXIS_tready,
  input  logic                     S_AXIS_tuser,
  input  logic                     S_AXIS_tlast,
  output logic [C_PIXEL_WIDTH-1:0] M_AXIS_tdata,
  output logic                     M_AXIS_tvalid,
  input  logic                     M_AXIS_tready,
  output logic                     M_AXIS_tuser,
  output logic                     M_AXIS_tlast
);

  localparam int AW    = $clog2(C_MAX_WIDTH);
  localparam int ACC_W = 2 * C_RES_WIDTH;
  localparam logic [C_RES_WIDTH-1:0] RES_ONE  = 1;
  localparam logic [C_RES_WIDTH:0]   LINE_ONE = 1;

  typedef enum logic {O_IDLE, O_LINE} ostate_t;

  // Input side
  logic                     r_run;
  logic                     r_frame;
  logic [C_RES_WIDTH-1:0]   r_ori_w, r_ori_h, r_scale_h;
  logic [C_RES_WIDTH-1:0]   r_in_col, r_in_line;
  logic                     r_wr_sel;
  logic [1:0]               r_buf_full;

  // Output side
  ostate_t                  r_ostate;
  logic                     r_rd_sel;
  logic [C_RES_WIDTH-1:0]   r_rd_col;
  logic [C_RES_WIDTH-1:0]   r_out_line;
  logic [ACC_W-1:0]         r_acc;

  logic                     r_rd_pend, r_rd_user, r_rd_last;
  logic [C_PIXEL_WIDTH-1:0] r_rd_data;
  logic                     r_skid_valid, r_skid_user, r_skid_last;
  logic [C_PIXEL_WIDTH-1:0] r_skid_data;
  logic                     r_out_valid, r_out_user, r_out_last;
  logic [C_PIXEL_WIDTH-1:0] r_out_data;

  logic [C_PIXEL_WIDTH-1:0] r_mem [0:2*C_MAX_WIDTH-1];

  logic                     w_unused;
  logic                     w_in_hs, w_sof, w_in_keep, w_in_eol, w_wr_en, w_line_done;
  logic [AW:0]              w_wr_addr, w_rd_addr;
  logic [1:0]               w_set, w_clr;
  logic [C_RES_WIDTH:0]     w_line_nxt;
  logic [ACC_W-1:0]         w_h_ext, w_s_ext, w_acc_add;
  logic                     w_more_lines, w_lines_left, w_last_col, w_replay;
  logic                     w_pop, w_load, w_room, w_issue;
  logic [1:0]               w_occ;
  logic                     w_idle_start, w_idle_drop, w_end_free, w_free;

  assign w_unused = ^{scale_width, S_AXIS_tlast};

  assign S_AXIS_tready = r_run & ~(&r_buf_full);
  assign w_in_hs       = S_AXIS_tvalid & S_AXIS_tready;
  assign w_sof         = w_in_hs & S_AXIS_tuser;
  assign w_in_keep     = r_frame & (r_in_line < r_ori_h);
  assign w_in_eol      = (r_in_col == r_ori_w - RES_ONE);
  assign w_wr_en       = w_sof | (w_in_hs & w_in_keep);
  assign w_wr_addr     = w_sof ? '0 : {r_wr_sel, AW'(r_in_col)};
  assign w_line_done   = w_in_hs & ~S_AXIS_tuser & w_in_keep & w_in_eol;
  assign w_set         = {r_wr_sel, ~r_wr_sel} & {2{w_line_done}};

  // Error accumulator: acc = j*ori_h - i*scale_h; output line j maps to the buffered line i while acc < scale_h.
  assign w_h_ext      = {{C_RES_WIDTH{1'b0}}, r_ori_h};
  assign w_s_ext      = {{C_RES_WIDTH{1'b0}}, r_scale_h};
  assign w_acc_add    = r_acc + w_h_ext;
  assign w_line_nxt   = {1'b0, r_out_line} + LINE_ONE;
  assign w_more_lines = w_line_nxt < {1'b0, r_scale_h};
  assign w_lines_left = r_out_line < r_scale_h;
  assign w_last_col   = (r_rd_col == r_ori_w - RES_ONE);
  assign w_replay     = w_more_lines & (w_acc_add < w_s_ext);

  // At most two beats live between the RAM read and the output register.
  assign w_pop   = r_out_valid & M_AXIS_tready;
  assign w_load  = ~r_out_valid | w_pop;
  assign w_occ   = {1'b0, r_out_valid} + {1'b0, r_skid_valid} + {1'b0, r_rd_pend};
  assign w_room  = (w_occ - {1'b0, w_pop}) < 2'd2;
  assign w_issue = (r_ostate == O_LINE) & w_room;

  assign w_idle_start = (r_ostate == O_IDLE) & r_buf_full[r_rd_sel] & w_lines_left & (r_acc < w_s_ext);
  assign w_idle_drop  = (r_ostate == O_IDLE) & r_buf_full[r_rd_sel] & ~(w_lines_left & (r_acc < w_s_ext));
  assign w_end_free   = w_issue & w_last_col & ~w_replay;
  assign w_free       = (w_idle_drop | w_end_free) & ~w_sof;
  assign w_clr        = {r_rd_sel, ~r_rd_sel} & {2{w_free}};
  assign w_rd_addr    = {r_rd_sel, AW'(r_rd_col)};

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_run     <= 1'b0;
      r_frame   <= 1'b0;
      r_ori_w   <= '0;
      r_ori_h   <= '0;
      r_scale_h <= '0;
      r_in_col  <= '0;
      r_in_line <= '0;
      r_wr_sel  <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (w_sof) begin
        r_frame   <= 1'b1;
        r_ori_w   <= ori_width;
        r_ori_h   <= ori_height;
        r_scale_h <= scale_height;
        r_in_col  <= RES_ONE;
        r_in_line <= '0;
        r_wr_sel  <= 1'b0;
      end else if (w_in_hs && r_frame) begin
        if (w_in_eol) begin
          r_in_col <= '0;
          if (w_in_keep) begin
            r_in_line <= r_in_line + RES_ONE;
            r_wr_sel  <= ~r_wr_sel;
          end
        end else begin
          r_in_col <= r_in_col + RES_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)    r_buf_full <= 2'b00;
    else if (w_sof) r_buf_full <= 2'b00;
    else            r_buf_full <= (r_buf_full | w_set) & ~w_clr;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ostate   <= O_IDLE;
      r_rd_sel   <= 1'b0;
      r_rd_col   <= '0;
      r_out_line <= '0;
      r_acc      <= '0;
    end else if (w_sof) begin
      r_ostate   <= O_IDLE;
      r_rd_sel   <= 1'b0;
      r_rd_col   <= '0;
      r_out_line <= '0;
      r_acc      <= '0;
    end else begin
      case (r_ostate)
        O_IDLE: begin
          if (w_idle_start) begin
            r_ostate <= O_LINE;
            r_rd_col <= '0;
          end else if (w_idle_drop) begin
            r_rd_sel <= ~r_rd_sel;
            if (w_lines_left) r_acc <= r_acc - w_s_ext;
          end
        end
        O_LINE: begin
          if (w_issue) begin
            if (w_last_col) begin
              r_out_line <= w_line_nxt[C_RES_WIDTH-1:0];
              r_rd_col   <= '0;
              if (w_replay) begin
                r_acc <= w_acc_add;
              end else begin
                r_acc    <= w_more_lines ? w_acc_add - w_s_ext : w_acc_add;
                r_rd_sel <= ~r_rd_sel;
                r_ostate <= O_IDLE;
              end
            end else begin
              r_rd_col <= r_rd_col + RES_ONE;
            end
          end
        end
        default: r_ostate <= O_IDLE;
      endcase
    end
  end

  // NOTE: the line-buffer RAM has no reset; its contents are only read after being written in the current frame.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_addr] <= S_AXIS_tdata;
    if (w_issue) r_rd_data <= r_mem[w_rd_addr];
  end

  // A beat already presented on M_AXIS survives an input SOF; everything behind it is flushed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_pend    <= 1'b0;
      r_rd_user    <= 1'b0;
      r_rd_last    <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_user  <= 1'b0;
      r_skid_last  <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_user   <= 1'b0;
      r_out_last   <= 1'b0;
    end else if (w_sof) begin
      r_rd_pend    <= 1'b0;
      r_skid_valid <= 1'b0;
      if (w_load) r_out_valid <= 1'b0;
    end else begin
      r_rd_pend <= w_issue;
      r_rd_user <= (r_out_line == '0) & (r_rd_col == '0);
      r_rd_last <= w_last_col;
      if (w_load) begin
        if (r_skid_valid) begin
          r_out_valid  <= 1'b1;
          r_out_data   <= r_skid_data;
          r_out_user   <= r_skid_user;
          r_out_last   <= r_skid_last;
          r_skid_valid <= r_rd_pend;
          r_skid_data  <= r_rd_data;
          r_skid_user  <= r_rd_user;
          r_skid_last  <= r_rd_last;
        end else if (r_rd_pend) begin
          r_out_valid <= 1'b1;
          r_out_data  <= r_rd_data;
          r_out_user  <= r_rd_user;
          r_out_last  <= r_rd_last;
        end else begin
          r_out_valid <= 1'b0;
        end
      end else if (r_rd_pend) begin
        r_skid_valid <= 1'b1;
        r_skid_data  <= r_rd_data;
        r_skid_user  <= r_rd_user;
        r_skid_last  <= r_rd_last;
      end
    end
  end

  assign M_AXIS_tvalid = r_out_valid;
  assign M_AXIS_tdata  = r_out_data;
  assign M_AXIS_tuser  = r_out_user;
  assign M_AXIS_tlast  = r_out_last;

endmodule

// File: tb/tb_yscaler_wrapper.sv
// Directed bench for yscaler_wrapper: expected beats are queued as frames are driven and
// compared as the DUT emits them.
module tb_yscaler_wrapper;

  typedef struct packed {
    logic [7:0] data;
    logic       user;
    logic       last;
  } beat_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [11:0] ori_height = 12'd10, ori_width = 12'd10, scale_height = 12'd10, scale_width = 12'd10;
  logic [7:0]  s_tdata = '0;
  logic        s_tvalid = 1'b0, s_tuser = 1'b0, s_tlast = 1'b0;
  logic        s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tuser, m_tlast;
  logic        m_tready = 1'b1;

  int    n_checks = 0, n_fail = 0;
  int    n_beats = 0, n_users = 0, n_acc = 0;
  int    gap_run = 0, max_gap = 0;
  bit    rand_ready = 1'b0, flush_ok = 1'b0, prev_stall = 1'b0;
  beat_t prev_beat, obs_b, exp_b;
  beat_t q[$];

  yscaler_wrapper dut (
    .clk          (clk),
    .resetn       (resetn),
    .ori_height   (ori_height),
    .ori_width    (ori_width),
    .scale_height (scale_height),
    .scale_width  (scale_width),
    .S_AXIS_tdata (s_tdata),
    .S_AXIS_tvalid(s_tvalid),
    .S_AXIS_tready(s_tready),
    .S_AXIS_tuser (s_tuser),
    .S_AXIS_tlast (s_tlast),
    .M_AXIS_tdata (m_tdata),
    .M_AXIS_tvalid(m_tvalid),
    .M_AXIS_tready(m_tready),
    .M_AXIS_tuser (m_tuser),
    .M_AXIS_tlast (m_tlast)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: checks hold-while-stalled, then scores each transferring beat.
  always @(negedge clk) begin
    if (!resetn) begin
      prev_stall = 1'b0;
      gap_run    = 0;
    end else begin
      obs_b = '{data: m_tdata, user: m_tuser, last: m_tlast};
      if (prev_stall) begin
        check("hold_valid", 32'(m_tvalid), 32'd1);
        check("hold_beat", 32'(obs_b), 32'(prev_beat));
      end
      m_tready   = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      prev_stall = m_tvalid && !m_tready;
      prev_beat  = obs_b;
      if (m_tvalid && m_tready) begin
        n_beats++;
        if (m_tuser) n_users++;
        if (!m_tuser && gap_run > max_gap) max_gap = gap_run;
        gap_run = 0;
        if (flush_ok && m_tuser)
          while (q.size() > 0 && !q[0].user) void'(q.pop_front());
        check("beat_expected", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          exp_b = q.pop_front();
          check("out_tdata", 32'(obs_b.data), 32'(exp_b.data));
          check("out_tuser", 32'(obs_b.user), 32'(exp_b.user));
          check("out_tlast", 32'(obs_b.last), 32'(exp_b.last));
        end
      end else if (!m_tvalid) begin
        gap_run++;
      end
    end
  end

  function automatic logic [7:0] pix(input int base, input int w, input int r, input int c);
    return 8'((base + r * w + c) & 255);
  endfunction

  task automatic push_frame(input int base, input int h, input int w, input int s);
    for (int k = 0; k < s; k++) begin
      int r;
      r = (k * h) / s;
      for (int c = 0; c < w; c++)
        q.push_back('{data: pix(base, w, r, c), user: (k == 0 && c == 0), last: (c == w - 1)});
    end
  endtask

  task automatic send_beat(input logic [7:0] d, input logic u);
    bit hs;
    int t;
    t = 0;
    @(negedge clk);
    s_tdata  = d;
    s_tuser  = u;
    s_tvalid = 1'b1;
    hs = s_tready;
    @(posedge clk);
    while (!hs && t < 2000) begin
      @(negedge clk);
      hs = s_tready;
      @(posedge clk);
      t++;
    end
    if (hs) n_acc++;
    else check("in_accept_timeout", 32'(hs), 32'd1);
  endtask

  task automatic send_lines(input int base, input int w, input int n_rows);
    for (int r = 0; r < n_rows; r++)
      for (int c = 0; c < w; c++)
        send_beat(pix(base, w, r, c), (r == 0 && c == 0));
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while (q.size() > 0 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_drain"}, 32'(q.size()), 32'd0);
    repeat (20) @(negedge clk);
  endtask

  task automatic start_test(input int h, input int s);
    ori_height   = 12'(h);
    scale_height = 12'(s);
    n_beats = 0;
    n_users = 0;
    n_acc   = 0;
    max_gap = 0;
  endtask

  initial begin
    // Reset held for five cycles
    repeat (5) begin
      @(negedge clk);
      check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
      check("rst_s_tready", 32'(s_tready), 32'd0);
    end
    #2 resetn = 1'b1;
    repeat (2) @(negedge clk);
    check("s_tready_after_rst", 32'(s_tready), 32'd1);

    // 10x10 -> 50 lines, pre-SOF junk dropped
    start_test(10, 50);
    for (int i = 0; i < 3; i++) send_beat(8'hE0 + 8'(i), 1'b0);
    push_frame(0, 10, 10, 50);
    send_lines(0, 10, 10);
    wait_drain("up");
    check("up_beats", 32'(n_beats), 32'd500);
    check("up_users", 32'(n_users), 32'd1);
    check("up_accepted", 32'(n_acc), 32'd103);

    // Same upscale with random output backpressure
    start_test(10, 50);
    rand_ready = 1'b1;
    push_frame(0, 10, 10, 50);
    send_lines(0, 10, 10);
    wait_drain("up_rand");
    rand_ready = 1'b0;
    check("up_rand_beats", 32'(n_beats), 32'd500);
    check("up_rand_users", 32'(n_users), 32'd1);

    // 10x10 -> 5 lines
    start_test(10, 5);
    push_frame(0, 10, 10, 5);
    send_lines(0, 10, 10);
    wait_drain("down");
    check("down_beats", 32'(n_beats), 32'd50);
    check("down_accepted", 32'(n_acc), 32'd100);

    // 1:1 pass-through, bubbles bounded
    start_test(10, 10);
    push_frame(0, 10, 10, 10);
    send_lines(0, 10, 10);
    wait_drain("unity");
    check("unity_beats", 32'(n_beats), 32'd100);
    check("unity_gap_le1", 32'(max_gap <= 1), 32'd1);

    // Reset mid-frame, then a clean frame
    start_test(10, 10);
    push_frame(0, 10, 10, 10);
    send_lines(0, 10, 4);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("midrst_m_tvalid", 32'(m_tvalid), 32'd0);
    check("midrst_m_tdata", 32'(m_tdata), 32'd0);
    check("midrst_m_tuser", 32'(m_tuser), 32'd0);
    check("midrst_m_tlast", 32'(m_tlast), 32'd0);
    check("midrst_s_tready", 32'(s_tready), 32'd0);
    q.delete();
    repeat (3) @(negedge clk);
    #2 resetn = 1'b1;
    start_test(10, 10);
    push_frame(33, 10, 10, 10);
    send_lines(33, 10, 10);
    wait_drain("post_rst");
    check("post_rst_beats", 32'(n_beats), 32'd100);
    check("post_rst_users", 32'(n_users), 32'd1);

    // Second SOF after three input lines
    start_test(10, 10);
    flush_ok = 1'b1;
    push_frame(0, 10, 10, 10);
    send_lines(0, 10, 3);
    push_frame(77, 10, 10, 10);
    send_lines(77, 10, 10);
    wait_drain("resof");
    flush_ok = 1'b0;
    check("resof_users", 32'(n_users), 32'd2);
    check("resof_min_beats", 32'(n_beats >= 100), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
